// File: rtl/serial_adder_if.sv
// Operand/result bundle between the APU sequencer and the bit-serial add/subtract unit.
// clk and reset stay plain ports on the modules that use this interface.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic             carryIn;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] f;
    logic             carryOut;
    logic             overflow;

    modport master (
        output start, sub, carryIn, a, b,
        input  busy, done, f, carryOut, overflow
    );

    modport slave (
        input  start, sub, carryIn, a, b,
        output busy, done, f, carryOut, overflow
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial add/subtract: one full-adder cell (two half adders plus an OR) processes the
// operands LSB first. The carry is held in a flop between cycles, and results appear with a one-cycle done pulse.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    serial_adder_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] op_a, op_b, acc;
    logic [CW-1:0]    count;
    logic             carry;
    logic [WIDTH-1:0] f_q;
    logic             carry_out_q, overflow_q;

    logic             accept, last;
    logic             hs, hc0, hc1, sum, carry_next;
    logic [WIDTH-1:0] acc_next;

    // The full-adder cell is always active; its result only matters while in SHIFT.
    half_adder ha_0 (.x(op_a[0]), .y(op_b[0]), .s(hs),  .c(hc0));
    half_adder ha_1 (.x(hs),      .y(carry),   .s(sum), .c(hc1));

    assign carry_next = hc0 | hc1;
    assign acc_next   = {sum, acc[WIDTH-1:1]};
    assign accept     = bus.start && (state == IDLE || state == DONE);
    assign last       = (count == CW'(WIDTH - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = SHIFT;
            SHIFT:   if (last)      state_next = DONE;
            DONE:    state_next = bus.start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: every datapath register is cleared on reset so an aborted operation leaves no residue.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_a        <= '0;
            op_b        <= '0;
            acc         <= '0;
            count       <= '0;
            carry       <= 1'b0;
            f_q         <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else if (accept) begin
            op_a  <= bus.a;
            op_b  <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub | bus.carryIn;
            acc   <= '0;
            count <= '0;
        end else if (state == SHIFT) begin
            op_a  <= op_a >> 1;
            op_b  <= op_b >> 1;
            carry <= carry_next;
            acc   <= acc_next;
            count <= count + CW'(1);
            // Visible results only move on the edge that enters DONE.
            if (last) begin
                f_q         <= acc_next;
                carry_out_q <= carry_next;
                overflow_q  <= carry ^ carry_next;
            end
        end
    end

    assign bus.busy     = (state == SHIFT);
    assign bus.done     = (state == DONE);
    assign bus.f        = f_q;
    assign bus.carryOut = carry_out_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed vector table, handshake corner
// sequences and randomized operations compared against a whole-word arithmetic model.
module tb_serial_adder;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(W)) bus_if ();
    serial_adder #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus_if));

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         cin;
        logic [W-1:0] f;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Whole-word reference: a + (b or ~b) + carry, overflow from operand/result signs.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input logic cin, output logic [W-1:0] f, output logic co,
                         output logic ov);
        logic [W-1:0] bb;
        logic [W:0]   total;
        bb    = sub ? ~b : b;
        total = {1'b0, a} + {1'b0, bb} + (W + 1)'(sub ? 1'b1 : cin);
        f     = total[W-1:0];
        co    = total[W];
        ov    = (a[W-1] == bb[W-1]) && (f[W-1] != a[W-1]);
    endtask

    // Issue one operation from IDLE or DONE, scramble the operand inputs after accept,
    // and check latency and busy length. Returns in the DONE cycle.
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic cin, output logic [W-1:0] f,
                         output logic co, output logic ov);
        int  lat;
        int  busy_n;
        bit  seen;
        bus_if.a       = a;
        bus_if.b       = b;
        bus_if.sub     = sub;
        bus_if.carryIn = cin;
        bus_if.start   = 1'b1;
        tick();
        bus_if.start   = 1'b0;
        bus_if.a       = W'($urandom);
        bus_if.b       = W'($urandom);
        bus_if.sub     = 1'($urandom);
        bus_if.carryIn = 1'($urandom);
        lat    = 99;
        busy_n = 0;
        seen   = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            if (bus_if.busy) busy_n++;
            tick();
            if (bus_if.done) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        check({tag, " latency"}, lat, W);
        check({tag, " busy cycles"}, busy_n, W);
        f  = bus_if.f;
        co = bus_if.carryOut;
        ov = bus_if.overflow;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rf, ef, prev_f, a_r, b_r;
        logic         rco, rov, eco, eov, s_r, c_r;
        int           done_n, first, second;

        vecs[0] = '{8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'hFF, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0};
        vecs[7] = '{8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1};

        reset          = 1'b1;
        bus_if.start   = 1'b0;
        bus_if.sub     = 1'b0;
        bus_if.carryIn = 1'b0;
        bus_if.a       = '0;
        bus_if.b       = '0;
        tick();
        tick();
        check("reset busy", bus_if.busy, 0);
        check("reset done", bus_if.done, 0);
        check("reset f", bus_if.f, 0);
        check("reset carryOut", bus_if.carryOut, 0);
        check("reset overflow", bus_if.overflow, 0);
        reset = 1'b0;
        tick();

        foreach (vecs[i]) begin
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin,
                  rf, rco, rov);
            check($sformatf("vec%0d f", i), rf, vecs[i].f);
            check($sformatf("vec%0d carryOut", i), rco, vecs[i].co);
            check($sformatf("vec%0d overflow", i), rov, vecs[i].ov);
        end

        // Start is re-asserted during SHIFT cycles 2-5 and must be ignored.
        prev_f         = bus_if.f;
        bus_if.a       = 8'h01;
        bus_if.b       = 8'h01;
        bus_if.sub     = 1'b0;
        bus_if.carryIn = 1'b0;
        bus_if.start   = 1'b1;
        tick();
        done_n = 0;
        rf     = '0;
        for (int c = 1; c <= 20; c++) begin
            if (c >= 2 && c <= 5) begin
                bus_if.start = 1'b1;
                bus_if.a     = 8'hAA;
                bus_if.b     = 8'h55;
            end else begin
                bus_if.start = 1'b0;
            end
            if (c <= 7) check($sformatf("busy-protect f held c%0d", c), bus_if.f, prev_f);
            tick();
            if (bus_if.done) begin
                done_n++;
                rf = bus_if.f;
            end
        end
        check("busy-protect done count", done_n, 1);
        check("busy-protect f", rf, 8'h02);

        // Reset on the 4th SHIFT cycle aborts without a done pulse.
        bus_if.a     = 8'h5A;
        bus_if.b     = 8'h33;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("abort busy", bus_if.busy, 0);
        check("abort done", bus_if.done, 0);
        check("abort f", bus_if.f, 0);
        check("abort carryOut", bus_if.carryOut, 0);
        check("abort overflow", bus_if.overflow, 0);
        reset  = 1'b0;
        done_n = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus_if.done) done_n++;
        end
        check("abort no done", done_n, 0);
        do_op("post-abort", 8'h03, 8'h04, 1'b0, 1'b0, rf, rco, rov);
        check("post-abort f", rf, 8'h07);
        tick();

        // Back-to-back with start held: second operands appear in the DONE cycle.
        bus_if.a       = 8'h10;
        bus_if.b       = 8'h01;
        bus_if.sub     = 1'b0;
        bus_if.carryIn = 1'b0;
        bus_if.start   = 1'b1;
        tick();
        first  = -1;
        second = -1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (bus_if.done) begin
                if (first < 0) begin
                    first = c;
                    check("b2b first f", bus_if.f, 8'h11);
                    bus_if.a = 8'h20;
                    bus_if.b = 8'h02;
                end else if (second < 0) begin
                    second = c;
                    check("b2b second f", bus_if.f, 8'h22);
                    bus_if.start = 1'b0;
                end
            end
        end
        bus_if.start = 1'b0;
        check("b2b first latency", first, W);
        check("b2b done spacing", second - first, W + 1);

        for (int n = 0; n < 40; n++) begin
            a_r = W'($urandom);
            b_r = W'($urandom);
            s_r = 1'($urandom);
            c_r = 1'($urandom);
            model(a_r, b_r, s_r, c_r, ef, eco, eov);
            do_op($sformatf("rnd%0d", n), a_r, b_r, s_r, c_r, rf, rco, rov);
            check($sformatf("rnd%0d f", n), rf, ef);
            check($sformatf("rnd%0d carryOut", n), rco, eco);
            check($sformatf("rnd%0d overflow", n), rov, eov);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
